// File: rtl/path_delay_probe.sv
// path_delay_probe: launch/capture controller for a chained inverter delay path.
// Toggles path_input, counts cycles until the synchronized chain output shows the
// expected level, accumulates 2^LOG2_SAMPLES launches and returns sum/average on a
// valid/ready handshake.
// Optional per-measurement min/max trackers: define PATH_PROBE_MINMAX_EN.
module path_delay_probe #(
    parameter int unsigned CNT_W        = 12,
    parameter int unsigned LOG2_SAMPLES = 3,
    parameter int unsigned TIMEOUT      = 4000,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned SETTLE       = 8,
    parameter int unsigned INVERT       = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          path_input,
    input  logic                          path_result,
    output logic [CNT_W-1:0]              result_avg,
    output logic [CNT_W+LOG2_SAMPLES-1:0] result_sum,
    output logic                          result_timeout,
`ifdef PATH_PROBE_MINMAX_EN
    output logic [CNT_W-1:0]              result_min,
    output logic [CNT_W-1:0]              result_max,
`endif
    output logic                          result_valid,
    input  logic                          result_ready
);

    localparam int unsigned SUM_W   = CNT_W + LOG2_SAMPLES;
    localparam int unsigned IX_W    = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
    localparam int unsigned LAST_IX = (1 << LOG2_SAMPLES) - 1;
    localparam int unsigned SET_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic        INV_BIT = (INVERT != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic [SET_W-1:0]       settle_cnt;
    logic [IX_W-1:0]        idx;
    logic [SUM_W-1:0]       acc;
    logic                   to_flag;

    logic                   rsync_c;
    logic                   match_c;
    logic                   timeout_c;
    logic [CNT_W-1:0]       count_c;
    logic [CNT_W-1:0]       sample_c;

    // Chain output is asynchronous; only the last synchronizer stage is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], path_result};
        end
    end

    // Count seen this cycle (includes the current WAIT cycle); timeout loses to a match.
    always_comb begin
        rsync_c   = sync_q[SYNC_STAGES-1];
        match_c   = (rsync_c == (path_input ^ INV_BIT));
        timeout_c = (cnt == CNT_W'(TIMEOUT - 1));
        count_c   = cnt + 1'b1;
        sample_c  = match_c ? count_c : CNT_W'(TIMEOUT);
    end

    // Measurement sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            path_input     <= 1'b0;
            cnt            <= '0;
            settle_cnt     <= '0;
            idx            <= '0;
            acc            <= '0;
            to_flag        <= 1'b0;
            result_avg     <= '0;
            result_sum     <= '0;
            result_timeout <= 1'b0;
            result_valid   <= 1'b0;
`ifdef PATH_PROBE_MINMAX_EN
            result_min     <= '0;
            result_max     <= '0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc     <= '0;
                        idx     <= '0;
                        to_flag <= 1'b0;
`ifdef PATH_PROBE_MINMAX_EN
                        result_min <= '1;
                        result_max <= '0;
`endif
                        busy    <= 1'b1;
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    path_input <= ~path_input;
                    cnt        <= '0;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= count_c;
                    if (match_c || timeout_c) begin
                        acc <= acc + SUM_W'(sample_c);
                        if (!match_c) begin
                            to_flag <= 1'b1;
                        end
`ifdef PATH_PROBE_MINMAX_EN
                        if (sample_c < result_min) begin
                            result_min <= sample_c;
                        end
                        if (sample_c > result_max) begin
                            result_max <= sample_c;
                        end
`endif
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SET_W'(SETTLE - 1)) begin
                        if (idx == IX_W'(LAST_IX)) begin
                            result_sum     <= acc;
                            result_avg     <= CNT_W'(acc >> LOG2_SAMPLES);
                            result_timeout <= to_flag;
                            result_valid   <= 1'b1;
                            busy           <= 1'b0;
                            state          <= ST_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_LAUNCH;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_delay_probe.sv
// tb_path_delay_probe: scoreboard bench for path_delay_probe with a behavioural
// chain model (per-launch delay line) and a second, inverting instance.
module tb_path_delay_probe;

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned L2      = 3;
    localparam int unsigned NS      = 8;
    localparam int unsigned TIMEOUT = 4000;
    localparam int unsigned SYNC    = 2;
    localparam int unsigned SUM_W   = CNT_W + L2;

    typedef struct {
        longint unsigned sum;
        longint unsigned avg;
        bit              to;
        longint unsigned mn;
        longint unsigned mx;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (INVERT=0)
    logic             rst_n, start, result_ready;
    logic             busy, path_input, path_result, result_timeout, result_valid;
    logic [CNT_W-1:0] result_avg;
    logic [SUM_W-1:0] result_sum;
`ifdef PATH_PROBE_MINMAX_EN
    logic [CNT_W-1:0] result_min, result_max;
`endif

    // inverting instance
    logic             start2;
    logic             ready2 = 1'b1;
    logic             busy2, pi2, pr2, to2, valid2;
    logic [CNT_W-1:0] avg2;
    logic [SUM_W-1:0] sum2;
`ifdef PATH_PROBE_MINMAX_EN
    logic [CNT_W-1:0] min2, max2;
`endif

    path_delay_probe u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .path_input(path_input), .path_result(path_result),
        .result_avg(result_avg), .result_sum(result_sum), .result_timeout(result_timeout),
`ifdef PATH_PROBE_MINMAX_EN
        .result_min(result_min), .result_max(result_max),
`endif
        .result_valid(result_valid), .result_ready(result_ready)
    );

    path_delay_probe #(.INVERT(1)) u_inv (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2),
        .path_input(pi2), .path_result(pr2),
        .result_avg(avg2), .result_sum(sum2), .result_timeout(to2),
`ifdef PATH_PROBE_MINMAX_EN
        .result_min(min2), .result_max(max2),
`endif
        .result_valid(valid2), .result_ready(ready2)
    );

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned dq[$];
    int unsigned dly = 5;
    int unsigned launch_cnt = 0;
    logic        last_pi = 1'b0;
    logic        last_pi2 = 1'b0;
    logic        pq[$];
    logic [8191:0] sr = '0;
    logic [7:0]    sr2 = '0;

    // Chain models: path_result is path_input seen through 'dly' flops.
    always @(posedge clk) sr <= {sr[8190:0], path_input};
    assign path_result = sr[13'(dly - 1)];
    always @(posedge clk) sr2 <= {sr2[6:0], pi2};
    assign pr2 = ~sr2[2];

    // Launch watcher: each path_input edge picks the next per-launch delay.
    always @(posedge clk) begin
        #1;
        if (path_input !== last_pi) begin
            last_pi = path_input;
            launch_cnt++;
            if (dq.size() > 0) dly = dq.pop_front();
        end
        if (pi2 !== last_pi2) begin
            last_pi2 = pi2;
            pq.push_back(pi2);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: per-launch count = delay + sync offset + 1, capped at TIMEOUT.
    function automatic exp_t model(input int unsigned d [NS]);
        exp_t e;
        longint unsigned c;
        e.sum = 0;
        e.to  = 1'b0;
        e.mn  = (64'd1 << CNT_W) - 1;
        e.mx  = 0;
        for (int i = 0; i < NS; i++) begin
            c = longint'(d[i]) + SYNC + 1;
            if (c > TIMEOUT) begin
                c = TIMEOUT;
                e.to = 1'b1;
            end
            e.sum += c;
            if (c < e.mn) e.mn = c;
            if (c > e.mx) e.mx = c;
        end
        e.avg = e.sum / NS;
        return e;
    endfunction

    // Monitor: compare every accepted result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && result_valid && result_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got sum %0d expected no result", result_sum);
            end else begin
                mon_e = sb.pop_front();
                check("res_sum", 64'(result_sum), mon_e.sum);
                check("res_avg", 64'(result_avg), mon_e.avg);
                check("res_timeout", 64'(result_timeout), 64'(mon_e.to));
`ifdef PATH_PROBE_MINMAX_EN
                check("res_min", 64'(result_min), mon_e.mn);
                check("res_max", 64'(result_max), mon_e.mx);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic launch_meas(input int unsigned d [NS], output exp_t e);
        e = model(d);
        for (int i = 0; i < NS; i++) dq.push_back(d[i]);
        sb.push_back(e);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", 64'(busy), 1);
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while (sb.size() != 0 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d pending results after %0d cycles expected 0", name, sb.size(), n);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 0);
        check({tag, "_path_input"}, 64'(path_input), 0);
        check({tag, "_avg"}, 64'(result_avg), 0);
        check({tag, "_sum"}, 64'(result_sum), 0);
        check({tag, "_timeout"}, 64'(result_timeout), 0);
        check({tag, "_valid"}, 64'(result_valid), 0);
`ifdef PATH_PROBE_MINMAX_EN
        check({tag, "_min"}, 64'(result_min), 0);
        check({tag, "_max"}, 64'(result_max), 0);
`endif
    endtask

    initial begin
        exp_t        e;
        int unsigned d [NS];
        int unsigned n;
        int unsigned base;

        rst_n = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        check_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) step();

        // Slow path beyond TIMEOUT: every launch times out.
        foreach (d[i]) d[i] = TIMEOUT + 2;
        launch_meas(d, e);
        drain("timeout_meas");

        // Nominal 5-cycle chain.
        foreach (d[i]) d[i] = 5;
        launch_meas(d, e);
        drain("nominal_meas");

        // Inverting 3-cycle chain on the second instance.
        pq.delete();
        step();
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        n = 0;
        while (!valid2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("inv_valid", 64'(valid2), 1);
        check("inv_avg", 64'(avg2), 6);
        check("inv_sum", 64'(sum2), 48);
        check("inv_timeout", 64'(to2), 0);
`ifdef PATH_PROBE_MINMAX_EN
        check("inv_min", 64'(min2), 6);
        check("inv_max", 64'(max2), 6);
`endif
        check("inv_launches", 64'(pq.size()), NS);
        for (int i = 0; i < NS && i < pq.size(); i++)
            check("inv_pi_alt", 64'(pq[i]), 64'((i % 2) == 0));
        repeat (3) step();

        // Randomized delays, with a start pulse while busy that must be ignored.
        repeat (4) begin
            foreach (d[i]) d[i] = $urandom_range(1, 10);
            launch_meas(d, e);
            repeat ($urandom_range(1, 5)) step();
            start = 1'b1;
            step();
            start = 1'b0;
            drain("rand_meas");
        end

        // Directed spread for the min/max trackers.
        d = '{2, 7, 4, 3, 6, 5, 2, 4};
        launch_meas(d, e);
        drain("minmax_meas");

        // Back-pressure in DONE: result held, starts ignored.
        step();
        result_ready = 1'b0;
        foreach (d[i]) d[i] = $urandom_range(1, 10);
        launch_meas(d, e);
        n = 0;
        while (!result_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("hold_valid_seen", 64'(result_valid), 1);
        for (int i = 0; i < 20; i++) begin
            step();
            start = ((i % 4) == 0);
            @(negedge clk);
            check("hold_valid", 64'(result_valid), 1);
            check("hold_busy", 64'(busy), 0);
            check("hold_sum", 64'(result_sum), e.sum);
            check("hold_avg", 64'(result_avg), e.avg);
        end
        step();
        start = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("valid_drop", 64'(result_valid), 0);
        check("idle_after_ack", 64'(busy), 0);
        drain("hold_meas");

        // Reset during WAIT of launch 3, then a fresh full measurement.
        foreach (d[i]) d[i] = 5;
        base = launch_cnt;
        launch_meas(d, e);
        n = 0;
        while (launch_cnt < base + 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", 64'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check_zero("mid_reset");
        sb.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        dq.delete();
        repeat (20) step();
        foreach (d[i]) d[i] = $urandom_range(1, 10);
        launch_meas(d, e);
        drain("post_reset_meas");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
